// File: rtl/cordic_z_sequencer_if.sv
// Handshake/ROM bundle between the CORDIC Z-constant sequencer and its
// environment (control, constant ROM, downstream datapath).
interface cordic_z_sequencer_if #(
    parameter int P = 32,
    parameter int D = 5
);
    logic         START;
    logic         ABORT;
    logic         EN_ROM1;
    logic [D-1:0] ADRS;
    logic [P-1:0] ROM_D;
    logic [P-1:0] Z_DATA;
    logic [D-1:0] Z_IDX;
    logic         Z_VALID;
    logic         Z_READY;
    logic         BUSY;
    logic         DONE;

    // Environment side: control, ROM data return and downstream ready.
    modport master (
        output START, ABORT, ROM_D, Z_READY,
        input  EN_ROM1, ADRS, Z_DATA, Z_IDX, Z_VALID, BUSY, DONE
    );

    // Sequencer side.
    modport slave (
        input  START, ABORT, ROM_D, Z_READY,
        output EN_ROM1, ADRS, Z_DATA, Z_IDX, Z_VALID, BUSY, DONE
    );
endinterface

// File: rtl/cordic_z_sequencer.sv
// Walks the CORDIC arctangent constant ROM from index 0 to ITER-1, presenting
// each constant to the datapath with a valid/ready handshake. Each element
// costs FETCH (ROM enable), LOAD (capture) and at least one HOLD cycle.
module cordic_z_sequencer #(
    parameter int P    = 32,
    parameter int D    = 5,
    parameter int ITER = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    cordic_z_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, FETCH, LOAD, HOLD} state_t;

    // Index of the final table entry; the counter stops here and never wraps.
    localparam logic [D-1:0] LAST_IDX = D'(ITER - 1);

    state_t       r_state;
    logic [D-1:0] r_idx;
    logic         r_en_rom1;
    logic [D-1:0] r_adrs;
    logic [P-1:0] r_z_data;
    logic [D-1:0] r_z_idx;
    logic         r_z_valid;
    logic         r_busy;
    logic         r_done;

    logic w_go;
    logic w_last;

    // Abort only matters for an accepted start; START+ABORT together is a no-op.
    assign w_go   = bus.START & ~bus.ABORT;
    assign w_last = (r_idx == LAST_IDX);

    // Sequencer FSM; every output comes straight from a register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_en_rom1 <= 1'b0;
            r_adrs    <= '0;
            r_z_data  <= '0;
            r_z_idx   <= '0;
            r_z_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != IDLE && bus.ABORT) begin
                // Cancel wins over everything, including a same-cycle handshake.
                // Z_DATA/Z_IDX are left holding the last captured element.
                r_state   <= IDLE;
                r_en_rom1 <= 1'b0;
                r_z_valid <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_go) begin
                            r_state   <= FETCH;
                            r_idx     <= '0;
                            r_adrs    <= '0;
                            r_en_rom1 <= 1'b1;
                            r_busy    <= 1'b1;
                        end
                    end
                    FETCH: begin
                        // ROM samples the enable at this edge; data is on ROM_D in LOAD.
                        r_en_rom1 <= 1'b0;
                        r_state   <= LOAD;
                    end
                    LOAD: begin
                        r_z_data  <= bus.ROM_D;
                        r_z_idx   <= r_idx;
                        r_z_valid <= 1'b1;
                        r_state   <= HOLD;
                    end
                    HOLD: begin
                        if (bus.Z_READY) begin
                            r_z_valid <= 1'b0;
                            if (!w_last) begin
                                r_idx     <= r_idx + 1'b1;
                                r_adrs    <= r_idx + 1'b1;
                                r_en_rom1 <= 1'b1;
                                r_state   <= FETCH;
                            end else begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.EN_ROM1 = r_en_rom1;
    assign bus.ADRS    = r_adrs;
    assign bus.Z_DATA  = r_z_data;
    assign bus.Z_IDX   = r_z_idx;
    assign bus.Z_VALID = r_z_valid;
    assign bus.BUSY    = r_busy;
    assign bus.DONE    = r_done;
endmodule
